// File: rtl/fetch_stage.sv
// fetch_stage -- RV32I instruction fetch stage.
//
// Holds the program counter and issues one instruction-memory request at a
// time. Each fetched word goes to decode through the IF/ID register together
// with its PC. Decode can stall the IF/ID register. Execute can redirect
// the PC for taken branches and jumps, which flushes IF/ID. A redirect also
// drops any response that belongs to the old path.
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   stall           in   decode cannot accept; IF/ID holds
//   redirect        in   taken branch/jump: load redirect_pc and flush
//   redirect_pc     in   redirect target (bits [1:0] forced to zero)
//   imem_req_valid  out  request valid
//   imem_req_ready  in   memory accepts the request this cycle
//   imem_addr       out  request address (always the PC register)
//   imem_resp_valid in   response data valid
//   imem_resp_data  in   fetched instruction word
//   if_valid        out  IF/ID holds a valid instruction
//   instruction     out  IF/ID instruction (NOP when invalid)
//   pc              out  PC of instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // st_req   : request presented, waiting for acceptance
  // st_wait  : request accepted, waiting for its response
  // st_hold  : response parked in the skid buffer while decode stalls
  // st_drain : a stale request is outstanding; swallow its response
  typedef enum logic [1:0] {
    st_req,
    st_wait,
    st_hold,
    st_drain
  } state_t;

  state_t      state_reg,      state_next;
  logic [31:0] pc_reg,         pc_next;
  logic        if_valid_reg,   if_valid_next;
  logic [31:0] if_instr_reg,   if_instr_next;
  logic [31:0] if_pc_reg,      if_pc_next;
  logic        skid_valid_reg, skid_valid_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [31:0] skid_pc_reg,    skid_pc_next;

  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  // Masking keeps every bit of redirect_pc in use while forcing word alignment.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4        = pc_reg + 32'd4;

  // Reset gates the request directly, so valid drops as soon as rst rises,
  // before any clock edge.
  assign imem_req_valid = (state_reg == st_req) && !rst;
  assign imem_addr      = pc_reg;
  assign if_valid       = if_valid_reg;
  assign instruction    = if_instr_reg;
  assign pc             = if_pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= st_req;
      pc_reg         <= RESET_PC;
      if_valid_reg   <= 1'b0;
      if_instr_reg   <= NOP;
      if_pc_reg      <= 32'h0000_0000;
      skid_valid_reg <= 1'b0;
      skid_instr_reg <= 32'h0000_0000;
      skid_pc_reg    <= 32'h0000_0000;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      if_valid_reg   <= if_valid_next;
      if_instr_reg   <= if_instr_next;
      if_pc_reg      <= if_pc_next;
      skid_valid_reg <= skid_valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    if_valid_next   = if_valid_reg;
    if_instr_next   = if_instr_reg;
    if_pc_next      = if_pc_reg;
    skid_valid_next = skid_valid_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;

    // IF/ID register. A redirect flushes it even while decode stalls.
    // Otherwise it changes only when decode can accept. In that case it
    // takes a fresh response, then the skid buffer, else a bubble.
    if (redirect) begin
      if_valid_next = 1'b0;
      if_instr_next = NOP;
    end else if (!stall) begin
      if (state_reg == st_wait && imem_resp_valid) begin
        if_valid_next = 1'b1;
        if_instr_next = imem_resp_data;
        if_pc_next    = pc_reg;
      end else if (state_reg == st_hold && skid_valid_reg) begin
        if_valid_next = 1'b1;
        if_instr_next = skid_instr_reg;
        if_pc_next    = skid_pc_reg;
      end else begin
        if_valid_next = 1'b0;
        if_instr_next = NOP;
      end
    end

    // Sequencer and PC. The PC of an outstanding request stays in pc_reg
    // until its response is consumed. That makes pc_reg the PC of the
    // word being delivered.
    unique case (state_reg)
      st_req: begin
        if (redirect) begin
          pc_next = redirect_target;
          // The old address was accepted on this very edge. Its response
          // must be drained before the new target can be requested.
          state_next = imem_req_ready ? st_drain : st_req;
        end else if (imem_req_ready) begin
          state_next = st_wait;
        end
      end
      st_wait: begin
        if (redirect) begin
          pc_next    = redirect_target;
          state_next = imem_resp_valid ? st_req : st_drain;
        end else if (imem_resp_valid) begin
          if (!stall) begin
            pc_next    = pc_plus4;
            state_next = st_req;
          end else begin
            skid_valid_next = 1'b1;
            skid_instr_next = imem_resp_data;
            skid_pc_next    = pc_reg;
            state_next      = st_hold;
          end
        end
      end
      st_hold: begin
        if (redirect) begin
          pc_next         = redirect_target;
          skid_valid_next = 1'b0;
          state_next      = st_req;
        end else if (!stall) begin
          pc_next         = pc_plus4;
          skid_valid_next = 1'b0;
          state_next      = st_req;
        end
      end
      st_drain: begin
        if (redirect) begin
          pc_next = redirect_target;
        end
        if (imem_resp_valid) begin
          state_next = st_req;
        end
      end
      default: begin
        state_next = st_req;
      end
    endcase

    // The buffered word belongs to the flushed path, so drop it.
    if (redirect) begin
      skid_valid_next = 1'b0;
      skid_instr_next = 32'h0000_0000;
      skid_pc_next    = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- bench for fetch_stage.
// A behavioural instruction memory returns addr ^ 32'hA5A5_0000 after a
// programmable delay. Expected (pc, word) pairs go into a scoreboard queue
// when each scenario is set up. A monitor pops one entry for every word
// newly written into IF/ID.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        if_valid;
  logic [31:0] instruction;
  logic [31:0] pc;

  int          n_checks = 0;
  int          n_pass = 0;
  int          resp_delay = 1;
  int          inject_req = 0;
  logic [63:0] sb[$];

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .instruction    (instruction),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Instruction memory: one outstanding request, response after resp_delay
  // cycles (1 = the cycle right after acceptance). inject_req forces one stray
  // response pulse.
  initial begin : mem_model
    logic        acc;
    logic        fire;
    logic [31:0] a_s;
    logic [31:0] m_addr;
    int          cnt;
    int          inject_done;
    bit          busy;
    busy = 1'b0; cnt = 0; m_addr = 32'h0; inject_done = 0;
    forever begin
      @(negedge clk);
      acc  = imem_req_valid && imem_req_ready && !rst;
      a_s  = imem_addr;
      fire = imem_resp_valid;
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 1'b0;
        imem_resp_valid = 1'b0;
      end else begin
        if (fire) imem_resp_valid = 1'b0;
        if (acc) begin
          busy = 1'b1;
          cnt = resp_delay;
          m_addr = a_s;
        end
        if (inject_req != inject_done && !busy) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = 32'hDEAD_BEEF;
          inject_done = inject_req;
        end else if (busy) begin
          if (cnt <= 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = m_addr ^ KEY;
            busy = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // IF/ID monitor: a valid word is new when the previous edge was unstalled.
  initial begin : monitor
    bit          stall_last;
    logic [63:0] e;
    stall_last = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && if_valid && !stall_last) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'(if_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          $display("deliver pc=%h instruction=%h", pc, instruction);
          check("deliv_pc", pc, e[63:32]);
          check("deliv_ins", instruction, e[31:0]);
        end
      end
      stall_last = stall;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    sb.push_back({a, a ^ KEY});
  endtask

  task automatic wait_empty(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset(input logic rdy, input int dly);
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    imem_req_ready = rdy;
    resp_delay = dly;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [6:0] pat;

    // Reset values and straight-line fetch
    rst = 1'b1;
    imem_req_ready = 1'b1;
    resp_delay = 1;
    step();
    @(negedge clk);
    check("rst_ifv", 32'(if_valid), 32'd0);
    check("rst_ins", instruction, NOP);
    check("rst_pc", pc, 32'h0);
    check("rst_reqv", 32'(imem_req_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h100);
    step();
    rst = 1'b0;
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    pat = 7'b1010100;
    for (int k = 0; k < 7; k++) begin
      if (k == 5) imem_req_ready = 1'b0;
      @(negedge clk);
      check("t1_ifv", 32'(if_valid), 32'(pat[k]));
      step();
    end
    wait_empty(20);

    // Stall capture into the skid buffer
    do_reset(1'b1, 1);
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    step(); step(); step();
    stall = 1'b1;
    step();
    @(negedge clk);
    check("t2_hold_reqv", 32'(imem_req_valid), 32'd0);
    check("t2_hold_ifv", 32'(if_valid), 32'd0);
    check("t2_hold_ins", instruction, NOP);
    step();
    @(negedge clk);
    check("t2_hold_reqv2", 32'(imem_req_valid), 32'd0);
    step();
    stall = 1'b0;
    step();
    @(negedge clk);
    check("t2_rel_ifv", 32'(if_valid), 32'd1);
    check("t2_rel_pc", pc, 32'h104);
    check("t2_rel_reqv", 32'(imem_req_valid), 32'd1);
    check("t2_rel_addr", imem_addr, 32'h108);
    step();
    imem_req_ready = 1'b0;
    @(negedge clk);
    check("t2_once_ifv", 32'(if_valid), 32'd0);
    wait_empty(20);

    // Redirect while waiting on a slow response
    do_reset(1'b1, 3);
    push_exp(32'h200);
    step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("t3_drain_reqv", 32'(imem_req_valid), 32'd0);
    check("t3_drain_addr", imem_addr, 32'h200);
    step();
    @(negedge clk);
    check("t3_drain_reqv2", 32'(imem_req_valid), 32'd0);
    step();
    @(negedge clk);
    check("t3_req_reqv", 32'(imem_req_valid), 32'd1);
    check("t3_req_addr", imem_addr, 32'h200);
    step();
    imem_req_ready = 1'b0;
    wait_empty(20);

    // Redirect in the same cycle as the response
    do_reset(1'b1, 1);
    push_exp(32'h200);
    step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("t4_reqv", 32'(imem_req_valid), 32'd1);
    check("t4_addr", imem_addr, 32'h200);
    check("t4_ifv0", 32'(if_valid), 32'd0);
    step();
    imem_req_ready = 1'b0;
    @(negedge clk);
    check("t4_ifv1", 32'(if_valid), 32'd0);
    step();
    @(negedge clk);
    check("t4_ifv2", 32'(if_valid), 32'd1);
    check("t4_pc", pc, 32'h200);
    step();
    wait_empty(10);

    // Backpressure, misaligned redirect, redirect with accepted stale request
    do_reset(1'b0, 1);
    push_exp(32'h300); push_exp(32'h400);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_bp_reqv", 32'(imem_req_valid), 32'd1);
      check("t5_bp_addr", imem_addr, 32'h100);
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h302;
    step();
    redirect = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    check("t5_redir_addr", imem_addr, 32'h300);
    check("t5_redir_reqv", 32'(imem_req_valid), 32'd1);
    step();
    imem_req_ready = 1'b0;
    step(); step();
    imem_req_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
    step();
    redirect = 1'b0; imem_req_ready = 1'b0;
    @(negedge clk);
    check("t5_drain_reqv", 32'(imem_req_valid), 32'd0);
    check("t5_drain_addr", imem_addr, 32'h400);
    step();
    imem_req_ready = 1'b1;
    @(negedge clk);
    check("t5_req_reqv", 32'(imem_req_valid), 32'd1);
    check("t5_req_addr", imem_addr, 32'h400);
    step();
    imem_req_ready = 1'b0;
    wait_empty(10);

    // PC wrap, then asynchronous reset while waiting
    do_reset(1'b0, 1);
    push_exp(32'hFFFF_FFFC); push_exp(32'h0000_0000);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0; imem_req_ready = 1'b1;
    step(); step(); step(); step();
    stall = 1'b1; resp_delay = 3;
    @(negedge clk);
    check("t6_wrap_ifv", 32'(if_valid), 32'd1);
    check("t6_wrap_pc", pc, 32'h0);
    step();
    imem_req_ready = 1'b0;
    #1;
    check("t6_pre_ifv", 32'(if_valid), 32'd1);
    check("t6_pre_addr", imem_addr, 32'h4);
    #1;
    rst = 1'b1;
    #1;
    check("t6_arst_ifv", 32'(if_valid), 32'd0);
    check("t6_arst_ins", instruction, NOP);
    check("t6_arst_pc", pc, 32'h0);
    check("t6_arst_reqv", 32'(imem_req_valid), 32'd0);
    check("t6_arst_addr", imem_addr, 32'h100);
    stall = 1'b0;
    step(); step();
    rst = 1'b0;
    resp_delay = 1;
    inject_req++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_stray_ifv", 32'(if_valid), 32'd0);
      check("t6_req_reqv", 32'(imem_req_valid), 32'd1);
      check("t6_req_addr", imem_addr, 32'h100);
      step();
    end
    push_exp(32'h100);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    wait_empty(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV32I pipeline: holds the program counter, issues one instruction-memory request at a time, and presents each fetched word with its PC to the decode stage through the IF/ID register. It honours the decode-side stall and the execute-side redirect for taken branches and jumps. A taken redirect flushes the IF/ID register and discards any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  decode cannot accept; IF/ID register holds.
- redirect  in  1  taken branch or jump; load `redirect_pc` and flush.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  request word address; always equals the PC register.
- imem_resp_valid  in  1  response data valid.
- imem_resp_data  in  32  fetched instruction word.
- if_valid  out  1  IF/ID register holds a valid instruction.
- instruction  out  32  IF/ID instruction; 32'h0000_0013 (NOP) when invalid.
- pc  out  32  PC of `instruction`.

## Operation
- **Reset:**
  - PC register = RESET_PC.
  - State = REQ.
  - if_valid = 0, instruction = 32'h0000_0013, pc = 0, imem_req_valid = 0 while rst is high.
  - The skid buffer is empty.
- **Transfer rule:** the IF/ID register is written only when stall = 0.
  - With no new word in a non-stalled cycle, if_valid goes to 0 and instruction goes to NOP.
- **REQ:**
  - imem_req_valid = 1, imem_addr = PC.
  - On imem_req_ready: go to WAIT.
  - Valid and address stay stable until accepted; only a redirect may change the address.
- **WAIT:** on imem_resp_valid:
  - If stall = 0: load the word and PC into IF/ID, set if_valid = 1, PC += 4, go to REQ.
  - If stall = 1: capture the word and PC into the one-entry skid buffer, go to HOLD.
- **HOLD:**
  - imem_req_valid = 0.
  - When stall = 0: move the buffer into IF/ID (if_valid = 1), PC += 4, go to REQ.
- **DRAIN:**
  - imem_req_valid = 0.
  - Wait for imem_resp_valid, discard the data, go to REQ.
- **Redirect:** highest priority, and it overrides stall.
  - PC = {redirect_pc[31:2], 2'b00}.
  - if_valid = 0, instruction = NOP.
  - Skid buffer is cleared.
- **Next state on redirect:**
  - REQ without imem_req_ready: go to REQ; the new address is presented next cycle.
  - REQ with imem_req_ready in the same cycle: go to DRAIN, because a stale request was accepted.
  - WAIT without imem_resp_valid: go to DRAIN.
  - WAIT with imem_resp_valid in the same cycle: drop the response and go to REQ.
  - HOLD: go to REQ.
  - DRAIN without imem_resp_valid: stay in DRAIN with the updated PC.
  - DRAIN with imem_resp_valid: go to REQ.
- **Ignored inputs:** imem_resp_valid is ignored in REQ and HOLD.
- **PC arithmetic:** modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- **Outstanding requests:** never more than one.

## Timing
- Zero-wait memory (ready = 1, response one cycle after acceptance): one instruction every 2 cycles.
  - Cycle N: REQ accepted.
  - Cycle N+1: response arrives.
  - Cycle N+2: if_valid = 1.
- Redirect asserted in cycle N (not DRAIN-bound): request for the target in N+1, response in N+2, if_valid with pc = target in N+3.
- Redirect that goes to DRAIN adds the stale response latency before the target is requested.
- Stall release from HOLD in cycle N: buffered word is on IF/ID in N+1, next request issued in N+1.
- Asynchronous reset mid-operation: all outputs take their reset values immediately, without waiting for a clock edge.
  - A memory response arriving after reset deassertion while in REQ is ignored.

## Test plan
- **Straight-line fetch:** RESET_PC = 0x100, zero-wait memory returning data = addr ^ 32'hA5A5_0000 -> if_valid pulses every 2 cycles with pc 0x100, 0x104, 0x108 and matching data.
- **Stall capture:** stall = 1 in the cycle a response for 0x104 arrives -> HOLD, imem_req_valid = 0, IF/ID unchanged. Release stall -> next cycle pc = 0x104 appears exactly once, then a request for 0x108 is issued.
- **Redirect during WAIT:** response delay 3 cycles, redirect to 0x200 while waiting -> DRAIN, stale word never reaches IF/ID, next valid pc = 0x200.
- **Redirect coincident with imem_resp_valid:** no DRAIN, request for 0x200 in the following cycle, if_valid with pc = 0x200 three cycles after the redirect.
- **Backpressure:** imem_req_ready = 0 for 5 cycles -> imem_req_valid = 1 and imem_addr stable throughout. Redirect to 0x302 under backpressure -> imem_addr = 0x300 next cycle.
- **Wrap and reset:** redirect to 0xFFFF_FFFC -> valid pcs 0xFFFF_FFFC, then 0x0000_0000. Assert rst in WAIT -> outputs at reset values immediately, first request after release at RESET_PC.
